branch_redirect_ctrl: RTL and testbench
=======================================

// Module: branch_redirect_ctrl
// PURPOSE
//  Collects branch/jump resolutions from both issue slots and checks each against
//  the fetch-stage prediction. Arbitrates redirects with program order (slot0 older).
//  Delivers one redirect to fetch over a valid/ready handshake, then holds a flush
//  window. Issues registered predictor-update strobes and keeps branch/mispredict counters.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles flush stays high after redirect handshake (0 allowed)
//  CNT_W         16  width of saturating statistics counters
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      async active-low reset
//  sN_valid      in   1      slot N (N=0,1) carries a resolved instr this cycle
//  sN_pc         in   32     slot N instr pc
//  sN_is_branch  in   1      slot N is B-type
//  sN_is_jump    in   1      slot N is jal/jalr
//  sN_taken      in   1      slot N actual outcome
//  sN_target     in   32     slot N actual target (meaningful only if taken)
//  sN_pred_taken in   1      fetch-stage prediction for slot N
//  sN_pred_tgt   in   32     predicted target (meaningful only if pred_taken)
//  redir_valid   out  1      redirect request to fetch
//  redir_ready   in   1      fetch accepts redirect
//  redir_pc      out  32     corrected next pc
//  flush         out  1      squash younger in-flight instrs
//  ex_stall      out  1      hold EX slots; high whenever state != IDLE
//  updN_valid    out  1      predictor update strobe for slot N (1-cycle pulse)
//  updN_pc       out  32     pc to update
//  updN_taken    out  1      actual outcome
//  updN_target   out  32     actual target
//  br_cnt        out  CNT_W  resolved branches+jumps, saturating
//  mis_cnt       out  CNT_W  mispredicts, saturating
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0. Reset mid-redirect aborts at once.
//  resN = sN_valid & (sN_is_branch|sN_is_jump).
//  misN = resN & ((sN_taken!=sN_pred_taken) | (sN_taken & sN_target!=sN_pred_tgt)).
//  nextN = sN_taken ? sN_target : sN_pc+32'd4 (mod 2^32).
//  Inputs are sampled only in IDLE. Otherwise they are ignored (upstream holds via ex_stall).
//  Slot1 is killed when mis0=1: no update, no count, no redirect from slot1.
//  Registered outputs, one cycle after sample edge:
//  - updN_valid = resN & alive(N), with pc/taken/target captured.
//  - br_cnt += number of live resolutions (0..2). mis_cnt += 1 when any live mispredict.
//  - Both counters saturate at all-ones.
//  FSM states:
//  - IDLE: on mis0|mis1 -> REDIR. Set redir_valid=1, flush=1.
//    redir_pc = mis0 ? next0 : next1.
//  - REDIR: redir_valid, redir_pc and flush held stable until redir_ready=1.
//    On handshake, redir_valid drops next cycle.
//    FLUSH_CYCLES>0 -> FLUSH with count=FLUSH_CYCLES. FLUSH_CYCLES=0 -> IDLE.
//  - FLUSH: flush=1; count decrements each cycle; at count==1 -> IDLE.
//  Latency:
//  - Mispredict sampled at edge N -> redir_valid high after edge N.
//  - redir_ready sampled at edge M -> flush low after edge M+FLUSH_CYCLES.
//  - ex_stall low again in the same cycle that flush drops.
//  redir_ready=1 already in the cycle redir_valid rises: handshake at the next edge.
//  redir_ready while not in REDIR: ignored.
// TESTING
//  1 s0 beq pc=0x100 taken tgt=0x140, pred taken 0x140 -> upd0 pulse; br_cnt=1; no redirect.
//  2 s0 bne pc=0x200 not-taken, pred_taken=1 -> redir_pc=0x204; flush, ex_stall high;
//    FLUSH_CYCLES=2: flush low 2 cycles after handshake.
//  3 both mispredict (s0 tgt 0x300, s1 tgt 0x400) -> redir_pc=0x300; upd1_valid=0; mis_cnt+1.
//  4 s1 jal pc=0x500 tgt 0x800, pred not-taken; redir_ready low 5 cycles ->
//    redir_valid/pc=0x800 stable; new inputs ignored; single handshake.
//  5 pc=0xFFFFFFFC not-taken mispredict -> redir_pc=0x0. Counter at 0xFFFF + branch -> stays 0xFFFF.
//  6 rst_n low while in REDIR -> all outputs 0 immediately; IDLE after release.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch resolution checker: arbitrates mispredict redirects across two slots,
// holds a flush window, and emits predictor updates plus branch statistics.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s0_valid,
  input  logic [31:0]      s0_pc,
  input  logic             s0_is_branch,
  input  logic             s0_is_jump,
  input  logic             s0_taken,
  input  logic [31:0]      s0_target,
  input  logic             s0_pred_taken,
  input  logic [31:0]      s0_pred_tgt,
  input  logic             s1_valid,
  input  logic [31:0]      s1_pc,
  input  logic             s1_is_branch,
  input  logic             s1_is_jump,
  input  logic             s1_taken,
  input  logic [31:0]      s1_target,
  input  logic             s1_pred_taken,
  input  logic [31:0]      s1_pred_tgt,
  output logic             redir_valid,
  input  logic             redir_ready,
  output logic [31:0]      redir_pc,
  output logic             flush,
  output logic             ex_stall,
  output logic             upd0_valid,
  output logic [31:0]      upd0_pc,
  output logic             upd0_taken,
  output logic [31:0]      upd0_target,
  output logic             upd1_valid,
  output logic [31:0]      upd1_pc,
  output logic             upd1_taken,
  output logic [31:0]      upd1_target,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt
);

  localparam int FC_W =
    (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    REDIR,
    FLUSH
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [31:0]     rpc_q;
  logic [31:0]     rpc_d;
  logic [FC_W-1:0] fcnt_q;
  logic [FC_W-1:0] fcnt_d;

  logic        idle;
  logic        res0;
  logic        res1;
  logic        mis0;
  logic        mis1;
  logic [31:0] next0;
  logic [31:0] next1;
  logic        live0;
  logic        live1;
  logic        live_mis;
  logic [1:0]  n_live;
  logic [CNT_W:0]   br_sum;
  logic [CNT_W-1:0] br_nxt;
  logic [CNT_W-1:0] mis_nxt;

  assign idle  = (state_q == IDLE);
  assign res0  = s0_valid & (s0_is_branch | s0_is_jump);
  assign res1  = s1_valid & (s1_is_branch | s1_is_jump);
  assign mis0  = res0 & ((s0_taken != s0_pred_taken) |
                 (s0_taken & (s0_target != s0_pred_tgt)));
  assign mis1  = res1 & ((s1_taken != s1_pred_taken) |
                 (s1_taken & (s1_target != s1_pred_tgt)));
  assign next0 = s0_taken ? s0_target : s0_pc + 32'd4;
  assign next1 = s1_taken ? s1_target : s1_pc + 32'd4;

  // An older mispredict squashes slot1 entirely.
  assign live0    = idle & res0;
  assign live1    = idle & res1 & ~mis0;
  assign live_mis = idle & (mis0 | mis1);
  assign n_live   = {1'b0, live0} + {1'b0, live1};

  assign br_sum  = {1'b0, br_cnt} + (CNT_W+1)'(n_live);
  assign br_nxt  = br_sum[CNT_W] ? '1 : br_sum[CNT_W-1:0];
  assign mis_nxt = (live_mis & ~(&mis_cnt)) ?
                   mis_cnt + 1'b1 : mis_cnt;

  always_comb begin
    state_d = state_q;
    rpc_d   = rpc_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (mis0 | mis1) begin
          state_d = REDIR;
          rpc_d   = mis0 ? next0 : next1;
        end
      end
      REDIR: begin
        if (redir_ready) begin
          if (FLUSH_CYCLES > 0) begin
            state_d = FLUSH;
            fcnt_d  = FC_W'(FLUSH_CYCLES);
          end else begin
            state_d = IDLE;
          end
        end
      end
      FLUSH: begin
        if (fcnt_q == FC_W'(1)) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rpc_q   <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rpc_q   <= rpc_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd0_valid  <= 1'b0;
      upd0_pc     <= '0;
      upd0_taken  <= 1'b0;
      upd0_target <= '0;
      upd1_valid  <= 1'b0;
      upd1_pc     <= '0;
      upd1_taken  <= 1'b0;
      upd1_target <= '0;
      br_cnt      <= '0;
      mis_cnt     <= '0;
    end else begin
      upd0_valid <= live0;
      upd1_valid <= live1;
      if (live0) begin
        upd0_pc     <= s0_pc;
        upd0_taken  <= s0_taken;
        upd0_target <= s0_target;
      end
      if (live1) begin
        upd1_pc     <= s1_pc;
        upd1_taken  <= s1_taken;
        upd1_target <= s1_target;
      end
      br_cnt  <= br_nxt;
      mis_cnt <= mis_nxt;
    end
  end

  assign redir_valid = (state_q == REDIR);
  assign redir_pc    = rpc_q;
  assign flush       = ~idle;
  assign ex_stall    = ~idle;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed vector bench for branch_redirect_ctrl: table of single-sample
// cases plus stall, early-ready, reset and saturation sequences.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s0_valid, s0_is_branch, s0_is_jump, s0_taken, s0_pred_taken;
  logic [31:0] s0_pc, s0_target, s0_pred_tgt;
  logic        s1_valid, s1_is_branch, s1_is_jump, s1_taken, s1_pred_taken;
  logic [31:0] s1_pc, s1_target, s1_pred_tgt;
  logic        redir_valid, redir_ready, flush, ex_stall;
  logic [31:0] redir_pc;
  logic        upd0_valid, upd0_taken, upd1_valid, upd1_taken;
  logic [31:0] upd0_pc, upd0_target, upd1_pc, upd1_target;
  logic [15:0] br_cnt, mis_cnt;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_pc(s0_pc), .s0_is_branch(s0_is_branch),
    .s0_is_jump(s0_is_jump), .s0_taken(s0_taken), .s0_target(s0_target),
    .s0_pred_taken(s0_pred_taken), .s0_pred_tgt(s0_pred_tgt),
    .s1_valid(s1_valid), .s1_pc(s1_pc), .s1_is_branch(s1_is_branch),
    .s1_is_jump(s1_is_jump), .s1_taken(s1_taken), .s1_target(s1_target),
    .s1_pred_taken(s1_pred_taken), .s1_pred_tgt(s1_pred_tgt),
    .redir_valid(redir_valid), .redir_ready(redir_ready),
    .redir_pc(redir_pc), .flush(flush), .ex_stall(ex_stall),
    .upd0_valid(upd0_valid), .upd0_pc(upd0_pc), .upd0_taken(upd0_taken),
    .upd0_target(upd0_target),
    .upd1_valid(upd1_valid), .upd1_pc(upd1_pc), .upd1_taken(upd1_taken),
    .upd1_target(upd1_target),
    .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  typedef struct {
    logic        v0, b0, j0, t0, pt0;
    logic [31:0] pc0, tg0, ptg0;
    logic        v1, b1, j1, t1, pt1;
    logic [31:0] pc1, tg1, ptg1;
    logic        e_u0, e_u1, e_rv;
    logic [31:0] e_rpc;
    int          e_br, e_mis;
  } vec_t;

  vec_t vecs[9];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   exp_br = 0;
  int   exp_mis = 0;

  function automatic vec_t mk(
    logic v0, logic b0, logic j0, logic t0, logic pt0,
    logic [31:0] pc0, logic [31:0] tg0, logic [31:0] ptg0,
    logic v1, logic b1, logic j1, logic t1, logic pt1,
    logic [31:0] pc1, logic [31:0] tg1, logic [31:0] ptg1,
    logic eu0, logic eu1, logic erv, logic [31:0] erpc,
    int ebr, int emis);
    vec_t r;
    r.v0 = v0; r.b0 = b0; r.j0 = j0; r.t0 = t0; r.pt0 = pt0;
    r.pc0 = pc0; r.tg0 = tg0; r.ptg0 = ptg0;
    r.v1 = v1; r.b1 = b1; r.j1 = j1; r.t1 = t1; r.pt1 = pt1;
    r.pc1 = pc1; r.tg1 = tg1; r.ptg1 = ptg1;
    r.e_u0 = eu0; r.e_u1 = eu1; r.e_rv = erv; r.e_rpc = erpc;
    r.e_br = ebr; r.e_mis = emis;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic set_in(input vec_t v);
    s0_valid = v.v0; s0_is_branch = v.b0; s0_is_jump = v.j0;
    s0_taken = v.t0; s0_pred_taken = v.pt0;
    s0_pc = v.pc0; s0_target = v.tg0; s0_pred_tgt = v.ptg0;
    s1_valid = v.v1; s1_is_branch = v.b1; s1_is_jump = v.j1;
    s1_taken = v.t1; s1_pred_taken = v.pt1;
    s1_pc = v.pc1; s1_target = v.tg1; s1_pred_tgt = v.ptg1;
  endtask

  task automatic clear_in();
    s0_valid = 0; s0_is_branch = 0; s0_is_jump = 0;
    s0_taken = 0; s0_pred_taken = 0;
    s0_pc = '0; s0_target = '0; s0_pred_tgt = '0;
    s1_valid = 0; s1_is_branch = 0; s1_is_jump = 0;
    s1_taken = 0; s1_pred_taken = 0;
    s1_pc = '0; s1_target = '0; s1_pred_tgt = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // handshake accepted at next edge, flush drops two edges later
  task automatic finish_redirect(input string nm);
    redir_ready = 1'b1;
    tick();
    redir_ready = 1'b0;
    chk({nm, "_rv_drop"}, 32'(redir_valid), 32'd0);
    chk({nm, "_flush_h1"}, 32'(flush), 32'd1);
    tick();
    chk({nm, "_flush_h2"}, 32'(flush), 32'd1);
    tick();
    chk({nm, "_flush_low"}, 32'(flush), 32'd0);
    chk({nm, "_stall_low"}, 32'(ex_stall), 32'd0);
  endtask

  initial begin
    vecs[0] = mk(1,1,0,1,1, 32'h100, 32'h140, 32'h140,
                 0,0,0,0,0, 32'h0, 32'h0, 32'h0,
                 1,0,0, 32'h0, 1, 0);
    vecs[1] = mk(1,1,0,0,1, 32'h200, 32'h0, 32'h240,
                 0,0,0,0,0, 32'h0, 32'h0, 32'h0,
                 1,0,1, 32'h204, 1, 1);
    vecs[2] = mk(1,1,0,1,0, 32'h280, 32'h300, 32'h0,
                 1,1,0,1,0, 32'h284, 32'h400, 32'h0,
                 1,0,1, 32'h300, 1, 1);
    vecs[3] = mk(0,0,0,0,0, 32'h0, 32'h0, 32'h0,
                 1,0,1,1,0, 32'h500, 32'h800, 32'h0,
                 0,1,1, 32'h800, 1, 1);
    vecs[4] = mk(1,1,0,0,1, 32'hFFFF_FFFC, 32'h0, 32'h10,
                 0,0,0,0,0, 32'h0, 32'h0, 32'h0,
                 1,0,1, 32'h0, 1, 1);
    vecs[5] = mk(1,1,0,0,0, 32'h600, 32'h0, 32'h0,
                 1,0,1,1,1, 32'h604, 32'h700, 32'h700,
                 1,1,0, 32'h0, 2, 0);
    vecs[6] = mk(1,0,0,1,0, 32'h650, 32'h900, 32'h0,
                 0,0,0,0,0, 32'h0, 32'h0, 32'h0,
                 0,0,0, 32'h0, 0, 0);
    vecs[7] = mk(1,1,0,1,1, 32'h900, 32'h940, 32'h980,
                 0,0,0,0,0, 32'h0, 32'h0, 32'h0,
                 1,0,1, 32'h940, 1, 1);
    vecs[8] = mk(1,1,0,0,0, 32'hA00, 32'h0, 32'h0,
                 1,1,0,0,1, 32'hA04, 32'h0, 32'hB00,
                 1,1,1, 32'hA08, 2, 1);

    clear_in();
    redir_ready = 1'b0;
    #2;
    chk("rst_rv", 32'(redir_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_stall", 32'(ex_stall), 32'd0);
    chk("rst_br", 32'(br_cnt), 32'd0);
    chk("rst_mis", 32'(mis_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      string nm;
      nm = $sformatf("v%0d", i);
      set_in(vecs[i]);
      tick();
      clear_in();
      exp_br  += vecs[i].e_br;
      exp_mis += vecs[i].e_mis;
      chk({nm, "_u0"}, 32'(upd0_valid), 32'(vecs[i].e_u0));
      chk({nm, "_u1"}, 32'(upd1_valid), 32'(vecs[i].e_u1));
      chk({nm, "_rv"}, 32'(redir_valid), 32'(vecs[i].e_rv));
      chk({nm, "_br"}, 32'(br_cnt), 32'(exp_br));
      chk({nm, "_mis"}, 32'(mis_cnt), 32'(exp_mis));
      if (vecs[i].e_u0) begin
        chk({nm, "_u0pc"}, upd0_pc, vecs[i].pc0);
        chk({nm, "_u0t"}, 32'(upd0_taken), 32'(vecs[i].t0));
      end
      if (vecs[i].e_u1) chk({nm, "_u1pc"}, upd1_pc, vecs[i].pc1);
      if (vecs[i].e_rv) begin
        chk({nm, "_rpc"}, redir_pc, vecs[i].e_rpc);
        chk({nm, "_flush"}, 32'(flush), 32'd1);
        chk({nm, "_stall"}, 32'(ex_stall), 32'd1);
        finish_redirect(nm);
      end else begin
        chk({nm, "_noflush"}, 32'(flush), 32'd0);
      end
    end

    // fetch back-pressure: redirect held, new inputs ignored
    s1_valid = 1; s1_is_jump = 1; s1_taken = 1;
    s1_pc = 32'h500; s1_target = 32'h800;
    tick();
    exp_br++; exp_mis++;
    chk("st_rv0", 32'(redir_valid), 32'd1);
    clear_in();
    for (int k = 0; k < 5; k++) begin
      s0_valid = 1; s0_is_branch = 1; s0_pred_taken = 1;
      s0_pc = 32'h1000 + 32'(k * 16);
      tick();
      chk($sformatf("st_rv%0d", k + 1), 32'(redir_valid), 32'd1);
      chk($sformatf("st_rpc%0d", k + 1), redir_pc, 32'h800);
      chk($sformatf("st_u0_%0d", k + 1), 32'(upd0_valid), 32'd0);
      chk($sformatf("st_br%0d", k + 1), 32'(br_cnt), 32'(exp_br));
    end
    clear_in();
    finish_redirect("st");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("st_single%0d", k), 32'(redir_valid), 32'd0);
    end

    // ready high before and during the redirect cycle
    redir_ready = 1'b1;
    tick();
    chk("er_idle_rv", 32'(redir_valid), 32'd0);
    chk("er_idle_fl", 32'(flush), 32'd0);
    s0_valid = 1; s0_is_branch = 1; s0_pred_taken = 1; s0_pc = 32'h2000;
    tick();
    clear_in();
    exp_br++; exp_mis++;
    chk("er_rv", 32'(redir_valid), 32'd1);
    chk("er_rpc", redir_pc, 32'h2004);
    tick();
    redir_ready = 1'b0;
    chk("er_rv_drop", 32'(redir_valid), 32'd0);
    chk("er_flush", 32'(flush), 32'd1);
    tick();
    tick();
    chk("er_flush_low", 32'(flush), 32'd0);
    chk("er_mis", 32'(mis_cnt), 32'(exp_mis));

    // reset in the middle of a redirect
    s0_valid = 1; s0_is_branch = 1; s0_pred_taken = 1; s0_pc = 32'h3000;
    tick();
    clear_in();
    chk("rr_rv", 32'(redir_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_br = 0; exp_mis = 0;
    chk("rr_rv0", 32'(redir_valid), 32'd0);
    chk("rr_flush0", 32'(flush), 32'd0);
    chk("rr_stall0", 32'(ex_stall), 32'd0);
    chk("rr_rpc0", redir_pc, 32'h0);
    chk("rr_u0", 32'(upd0_valid), 32'd0);
    chk("rr_br0", 32'(br_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rr_idle_rv", 32'(redir_valid), 32'd0);
    chk("rr_idle_st", 32'(ex_stall), 32'd0);

    // counter saturation with two correct branches per cycle
    s0_valid = 1; s0_is_branch = 1; s0_pc = 32'h40;
    s1_valid = 1; s1_is_branch = 1; s1_pc = 32'h44;
    repeat (32767) @(posedge clk);
    #1;
    chk("sat_fffe", 32'(br_cnt), 32'h0000_FFFE);
    tick();
    chk("sat_ffff", 32'(br_cnt), 32'h0000_FFFF);
    s1_valid = 0;
    tick();
    chk("sat_hold", 32'(br_cnt), 32'h0000_FFFF);
    chk("sat_mis", 32'(mis_cnt), 32'd0);
    clear_in();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
